// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, odd parity, stop bit, paced by the s_ticks oversampling tick.
// tx is registered (1 clk from acceptance to the start-bit edge); tx_start is ignored while busy.
module uart_tx #(
  parameter int Data_bits = 9,
  parameter int Dt_ticks  = 16,
  parameter int Sp_ticks  = 16
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 s_ticks,
  input  logic                 tx_start,
  input  logic [Data_bits-2:0] data_in,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int DW   = Data_bits - 1;
  localparam int MaxT = (Dt_ticks > Sp_ticks) ? Dt_ticks : Sp_ticks;
  localparam int TW   = (MaxT > 2) ? $clog2(MaxT) : 1;
  localparam int BW   = (Data_bits > 2) ? $clog2(Data_bits) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic [BW-1:0] r_bit, w_bit_nxt;
  logic [DW-1:0] r_shift, w_shift_nxt, w_shifted;
  logic          r_parity, w_parity_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_done;
  logic          w_dt_last, w_sp_last;

  assign w_dt_last = s_ticks && (r_tick == TW'(Dt_ticks - 1));
  assign w_sp_last = s_ticks && (r_tick == TW'(Sp_ticks - 1));
  assign w_shifted = r_shift >> 1;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_tick   <= w_tick_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_tx     <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_tx_nxt     = r_tx;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (tx_start) begin
          w_shift_nxt  = data_in;
          w_parity_nxt = ~(^data_in);
          w_tick_nxt   = '0;
          w_state_nxt  = S_START;
          w_tx_nxt     = 1'b0;
        end
      end
      S_START: begin
        if (w_dt_last) begin
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end else if (s_ticks) begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      S_DATA: begin
        if (w_dt_last) begin
          w_tick_nxt  = '0;
          w_shift_nxt = w_shifted;
          if (r_bit == BW'(Data_bits - 2)) begin
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_parity;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
            w_tx_nxt  = w_shifted[0];
          end
        end else if (s_ticks) begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      S_PARITY: begin
        if (w_dt_last) begin
          w_tick_nxt  = '0;
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end else if (s_ticks) begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      S_STOP: begin
        // Done fires in the last stop-tick cycle; busy stays high until idle is reached.
        if (w_sp_last) begin
          w_tick_nxt  = '0;
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
          w_done      = 1'b1;
        end else if (s_ticks) begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign tx           = r_tx;
  assign tx_busy      = (r_state != S_IDLE);
  assign tx_done_tick = w_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frames queued on acceptance, decoded tick-by-tick off the line and compared.
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       Reset;
  logic       s_ticks;
  logic       tx_start;
  logic [7:0] data_in;
  logic       tx, tx_busy, tx_done_tick;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx dut (
    .clk(clk), .Reset(Reset), .s_ticks(s_ticks), .tx_start(tx_start),
    .data_in(data_in), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  logic [10:0] sb[$];
  logic        tick_en;
  int          div;
  bit          mon_active;
  bit          mon_pend;
  int          mon_tick;
  int          glitch;
  int          spurious;
  logic [10:0] rx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d);
    return {1'b1, ~(^d), d, 1'b0};
  endfunction

  // tick generator: one s_ticks every 4 clks while enabled
  initial begin
    s_ticks = 1'b0;
    div = 0;
    forever begin
      @(posedge clk); #2;
      s_ticks = tick_en && (div == 3);
      div = (div + 1) % 4;
    end
  end

  // line monitor: slot = tick/16; first tick of slot captures the level, the rest must match
  initial begin
    logic [10:0] exp_f;
    int slot;
    mon_active = 0; mon_pend = 0; mon_tick = 0; glitch = 0; spurious = 0; rx = '0;
    forever begin
      @(negedge clk);
      if (Reset === 1'b1) begin
        mon_active = 0;
        mon_pend   = 0;
      end else begin
        if (mon_pend) begin
          chk("busy_fall", tx_busy, 0);
          mon_pend = 0;
        end
        if (tx_done_tick === 1'b1 && !(mon_active && s_ticks && mon_tick == 175))
          spurious++;
        if (!mon_active && tx === 1'b0) begin
          mon_active = 1; mon_tick = 0; glitch = 0; rx = '0;
        end
        if (mon_active && s_ticks) begin
          slot = mon_tick / 16;
          if (mon_tick % 16 == 0) rx[slot] = tx;
          else if (tx !== rx[slot]) glitch++;
          if (mon_tick < 175 && tx_done_tick === 1'b1) chk("done_early", 1, 0);
          if (mon_tick == 175) begin
            chk("done_at_176", tx_done_tick, 1);
            chk("bit_level_stable", glitch, 0);
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else begin
              exp_f = sb.pop_front();
              chk("frame", rx, exp_f);
            end
            mon_active = 0;
            mon_pend   = 1;
          end
          mon_tick++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (tx_busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk("send_timeout", 1, 0);
    @(posedge clk); #2;
    tx_start = 1'b1; data_in = d; sb.push_back(frame(d));
    @(posedge clk); #2;
    tx_start = 1'b0; data_in = ~d;
    @(negedge clk);
    chk("accept_tx0", tx, 0);
    chk("accept_busy", tx_busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((mon_active || sb.size() != 0 || tx_busy !== 1'b0) && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) chk("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tick(input int t);
    int n = 0;
    while (!(mon_active && mon_tick >= t) && n < 5000) begin @(posedge clk); n++; end
    if (n >= 5000) chk("tick_timeout", 1, 0);
  endtask

  initial begin
    logic [7:0] vals [3];
    logic held;
    int held_tick, n;
    vals[0] = 8'h11; vals[1] = 8'h80; vals[2] = 8'hE7;
    Reset = 1'b1; tick_en = 1'b1; tx_start = 1'b0; data_in = 8'h00;

    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done_tick, 0);
    end
    @(posedge clk); #2; Reset = 1'b0;

    send(8'hA5); wait_idle();
    send(8'h07); wait_idle();
    send(8'h00); wait_idle();

    // start request during the data phase must be ignored
    send(8'h3C);
    wait_tick(40);
    @(posedge clk); #2; tx_start = 1'b1; data_in = 8'hFF;
    repeat (3) @(posedge clk);
    #2; tx_start = 1'b0;
    @(negedge clk); chk("busy_mid_frame", tx_busy, 1);
    wait_idle();

    // tx_start held high: back-to-back frames with a single idle clk between
    @(posedge clk); #2; tx_start = 1'b1; data_in = vals[0]; sb.push_back(frame(vals[0]));
    for (int i = 0; i < 3; i++) begin
      n = 0;
      @(negedge clk);
      while (tx_done_tick !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
      if (n >= 5000) chk("held_done_timeout", 1, 0);
      @(posedge clk); #2;
      if (i < 2) begin
        data_in = vals[i+1]; sb.push_back(frame(vals[i+1]));
        @(negedge clk); chk("gap_tx_idle", tx, 1); chk("gap_busy", tx_busy, 0);
        @(negedge clk); chk("gap_next_start", tx, 0);
      end else begin
        tx_start = 1'b0;
      end
    end
    wait_idle();

    // reset during parity aborts the frame without a done pulse
    send(8'hC3);
    wait_tick(150);
    @(posedge clk); #2; Reset = 1'b1;
    @(posedge clk); #2; Reset = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("abort_tx", tx, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_done", tx_done_tick, 0);
    repeat (200) @(negedge clk);
    chk("abort_stays_idle", {tx, tx_busy}, 2'b10);
    send(8'h5A); wait_idle();

    // freeze the tick mid data bit; the line must hold and the frame resume intact
    send(8'h96);
    wait_tick(60);
    @(posedge clk); #2; tick_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    held = tx; held_tick = mon_tick; n = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== held || tx_busy !== 1'b1) n++;
    end
    chk("freeze_line", n, 0);
    chk("freeze_ticks", mon_tick, held_tick);
    @(posedge clk); #2; tick_en = 1'b1;
    wait_idle();

    chk("no_spurious_done", spurious, 0);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter FSM and the upstream partner of the UART receiver on the serial line.
- Accepts a parallel data word through a start/busy handshake.
- Serialises the frame LSB-first on `tx`: start bit, data bits, odd-parity bit, stop bit.
- Bit timing comes from the shared oversampling tick `s_ticks` (16 ticks per bit by default), the same tick the receiver uses.

Parameters:
- Data_bits, 9: total bits per frame excluding start/stop (data + 1 parity). Data width = Data_bits-1.
- Dt_ticks, 16: s_ticks per start, data or parity bit.
- Sp_ticks, 16: s_ticks per stop bit.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- s_ticks  in  1  oversampling tick, one-clk pulse; bit timing advances only on cycles where it is 1.
- tx_start  in  1  request to send data_in; sampled only when idle.
- data_in  in  Data_bits-1  word to transmit; captured on acceptance.
- tx  out  1  serial line, registered; idles high.
- tx_busy  out  1  high from the cycle after acceptance until the frame ends.
- tx_done_tick  out  1  one-clk pulse at end of stop bit.

Behaviour:
- Reset (synchronous, clk edge with Reset=1) forces:
  - state=idle, tx=1, tx_busy=0, tx_done_tick=0;
  - tick counter, bit counter, shift register and parity register cleared.
- Reset has priority over all other inputs. Asserting Reset mid-frame aborts the frame; tx returns to 1 on the next edge. No done pulse is generated.
- States: idle, start, data, parity, stop.
  - tx is driven from a registered tx_reg.
  - tx_busy=1 in every state except idle.
- idle:
  - tx=1.
  - If tx_start=1 on an edge: capture data_in into the shift register, compute parity = ~(^data_in) (odd parity), clear the tick counter, go to start.
  - tx=0 from that same edge, so latency from tx_start to the line falling is 1 clk.
  - s_ticks is not required for acceptance.
- start:
  - tx=0.
  - On each s_ticks, increment the tick counter.
  - On the s_ticks where counter==Dt_ticks-1: clear the counter and bit counter, go to data, drive tx=shift[0].
- data:
  - tx=shift[0].
  - On each s_ticks, increment the tick counter.
  - At counter==Dt_ticks-1:
    - clear the counter;
    - shift right by 1;
    - if bit counter==Data_bits-2, go to parity and drive tx=parity bit;
    - else increment the bit counter and drive the next bit.
- parity:
  - tx=parity bit for Dt_ticks ticks.
  - Then clear the counter, go to stop, drive tx=1.
- stop:
  - tx=1 for Sp_ticks ticks.
  - On the final tick, assert tx_done_tick combinationally for that one clk and go to idle.
  - tx_busy remains 1 in that cycle.
- Frame length = Dt_ticks*(Data_bits+1) + Sp_ticks ticks. Default: 160+16 = 176 ticks.
- Tick counter width = $clog2(max(Dt_ticks, Sp_ticks)). Bit counter width = $clog2(Data_bits). No overflow is possible.
- Cycles without s_ticks hold all counters and tx.
- Busy/done boundary:
  - tx_start while tx_busy=1 is ignored and data_in is not re-captured.
  - tx_start in the tx_done_tick cycle is ignored.
  - tx_start one clk later is accepted; the minimum gap is 1 idle clk at tx=1.
- data_in changes after acceptance have no effect on the frame in flight.

Test Plan:
- Reset high 2 clks, with s_ticks toggling 1-in-4 → tx=1, tx_busy=0, tx_done_tick=0 throughout.
- tx_start with data_in=0xA5 (defaults) → expected response:
  - tx holds each level for 16 ticks: 0 (start), data bits 1,0,1,0,0,1,0,1, parity 1, then 1 (stop);
  - tx_done_tick pulses exactly once, 176 ticks after the start bit began;
  - tx_busy falls the clk after.
- data_in=0x07 → parity bit 0. data_in=0x00 → parity bit 1, data bits all 0.
- Mid-frame checks:
  - tx_start with data_in=0xFF asserted during data state of a 0x3C frame → frame continues as 0x3C; 0xFF is never sent.
  - tx_start held high continuously → frames repeat with exactly 1 idle clk (tx=1) between tx_done_tick and the next start bit.
- Reset asserted in the parity state → tx=1 and tx_busy=0 on the next edge, no tx_done_tick. A subsequent 0x5A frame is transmitted correctly.
- s_ticks gated low for 50 clks mid-data bit → tx and counters frozen; the frame resumes with the correct remaining tick count.
